// File: rtl/fifo_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_out
// Description : Read-side adapter for a synchronous FIFO with one-cycle
//               registered read latency. Issues read strobes from registered
//               state only, captures returned words into a 3-entry skid
//               buffer and presents them as a valid/ready stream with
//               fixed-length packet framing on m_last.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_out #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    // FIFO read interface
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_empty,
    // Stream output
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    // Status
    output logic [1:0]       occupancy,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                  c_BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(PKT_LEN - 1);
    localparam logic [2:0]          c_DEPTH     = 3'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]    r_buf [0:2];
    logic [1:0]          r_head;
    logic [1:0]          r_tail;
    logic [1:0]          r_count;
    logic                r_inflight;
    logic [c_BEAT_W-1:0] r_beat;

    logic [2:0]          w_level;
    logic                w_rd_en;
    logic                w_valid;
    logic                w_pop;
    logic [1:0]          w_count_next;
    logic [c_BEAT_W-1:0] w_beat_next;

    // Ring pointer increment over three slots: 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] f_ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // ------------------------------------------------------------------------
    // Read issue: a slot is reserved for every word either buffered or on its
    // way back from the FIFO, so a returning word always finds free space.
    // Only registered state and fifo_empty feed this path; m_ready does not.
    // ------------------------------------------------------------------------
    assign w_level = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_rd_en = !rst && !fifo_empty && (w_level < c_DEPTH);

    // ------------------------------------------------------------------------
    // Stream handshake
    // ------------------------------------------------------------------------
    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid && m_ready;

    // Next buffer level: a capture and a pop in the same cycle cancel out.
    always_comb begin
        w_count_next = r_count;
        case ({r_inflight, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Next beat position within the packet, wrapping after the last beat.
    always_comb begin
        w_beat_next = r_beat;
        if (w_pop) begin
            if (r_beat == c_LAST_BEAT) begin
                w_beat_next = '0;
            end else begin
                w_beat_next = r_beat + c_BEAT_W'(1);
            end
        end
    end

    // Control state: pointers, level, in-flight flag and packet position.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
            r_beat     <= '0;
        end else begin
            r_inflight <= w_rd_en;
            r_count    <= w_count_next;
            r_beat     <= w_beat_next;
            if (r_inflight) begin
                r_tail <= f_ptr_next(r_tail);
            end
            if (w_pop) begin
                r_head <= f_ptr_next(r_head);
            end
        end
    end

    // Data storage: write the word returned by last cycle's read. Contents
    // are don't-care after reset, so no reset is applied here.
    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_buf[r_tail] <= fifo_rd_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all but fifo_rd_en come straight from registered state)
    // ------------------------------------------------------------------------
    assign fifo_rd_en = w_rd_en;
    assign m_valid    = w_valid;
    assign m_data     = r_buf[r_head];
    assign m_last     = w_valid && (r_beat == c_LAST_BEAT);
    assign occupancy  = r_count;
    assign busy       = w_valid || r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_out
// Description : Self-checking bench for fifo_stream_out. A behavioural FIFO
//               with registered read latency feeds the DUT; expected beats
//               are queued as words are written and a monitor compares every
//               accepted beat, plus per-cycle stream and reset checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_out;

    localparam int WIDTH   = 8;
    localparam int PKT_LEN = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rd_data = '0;
    logic             fifo_empty = 1'b1;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic [1:0]       occupancy;
    logic             busy;

    always #5 clk = ~clk;

    fifo_stream_out #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .occupancy    (occupancy),
        .busy         (busy)
    );

    // Scoreboard and bookkeeping
    logic [WIDTH:0]   sb [$];         // {expected last, expected data}
    logic [WIDTH-1:0] fifo_q [$];
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    int               wr_idx = 0;     // words written since reset
    int               rd_cnt = 0;     // read strobes seen
    int               pop_cnt = 0;
    logic             inflight_tb = 1'b0;
    int               n_vec = 0;
    int               n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a FIFO write and queue the beat it must become. The packet
    // position of a word equals its write index since reset.
    task automatic write_word(input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        sb.push_back({((wr_idx % PKT_LEN) == PKT_LEN - 1), d});
        wr_idx++;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        m_ready = 1'b0;
        rst     = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int k = 0;
        while ((sb.size() != 0 || fifo_q.size() != 0 || busy) && k < max_cycles) begin
            tick();
            k++;
        end
        check(name, {31'd0, (sb.size() == 0 && fifo_q.size() == 0 && !busy)}, 32'd1);
    endtask

    // Behavioural synchronous FIFO: empty flag and read data are registered.
    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            sb.delete();
            wr_idx = 0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en) begin
                rd_cnt++;
                if (fifo_q.size() > 0) begin
                    fifo_rd_data <= fifo_q.pop_front();
                end
            end
            if (wr_en) begin
                fifo_q.push_back(wr_data);
            end
            fifo_empty <= (fifo_q.size() == 0);
        end
        inflight_tb <= fifo_rd_en;
    end

    // Monitor: reset behaviour, stream rules and scoreboard comparison.
    logic             prev_rst = 1'b0;
    logic             armed = 1'b0;
    logic             hold_pending = 1'b0;
    logic [WIDTH-1:0] hold_data = '0;
    logic             hold_last = 1'b0;

    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (rst) begin
            check("rd_en_in_reset", {31'd0, fifo_rd_en}, 32'd0);
        end
        if (prev_rst) begin
            check("rst_valid", {31'd0, m_valid}, 32'd0);
            check("rst_last", {31'd0, m_last}, 32'd0);
            check("rst_occupancy", {30'd0, occupancy}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            armed = 1'b1;
        end else if (armed) begin
            check("rd_while_empty", {31'd0, (fifo_rd_en && fifo_empty)}, 32'd0);
            n_vec++;
            assert (!(inflight_tb && occupancy == 2'd3)) else begin
                n_err++;
                $display("FAIL capture_full: capture arrives with occupancy %0d, required < 3", occupancy);
            end
            check("busy", {31'd0, busy}, {31'd0, (occupancy != 2'd0 || inflight_tb)});
            check("valid_vs_occ", {31'd0, m_valid}, {31'd0, (occupancy != 2'd0)});
            if (!m_valid) begin
                check("last_without_valid", {31'd0, m_last}, 32'd0);
            end
            if (hold_pending) begin
                check("hold_valid", {31'd0, m_valid}, 32'd1);
                check("hold_data", {24'd0, m_data}, {24'd0, hold_data});
                check("hold_last", {31'd0, m_last}, {31'd0, hold_last});
            end
            if (!rst && m_valid && m_ready) begin
                pop_cnt++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL beat_unexpected: got data 0x%0h, required no beat", m_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", {24'd0, m_data}, {24'd0, e[WIDTH-1:0]});
                    check("beat_last", {31'd0, m_last}, {31'd0, e[WIDTH]});
                end
            end
        end
        hold_pending = armed && !rst && m_valid && !m_ready;
        hold_data    = m_data;
        hold_last    = m_last;
        prev_rst     = rst;
    end

    // Directed and randomized stimulus
    initial begin
        int  base;
        int  k;
        logic done;

        // Power-on reset
        do_reset(2);

        // 1. Reset for two cycles while the FIFO and buffer hold data
        for (int i = 0; i < 6; i++) write_word(8'(8'hC0 + i));
        repeat (6) tick();
        check("t1_preload_occ", {30'd0, occupancy}, 32'd3);
        do_reset(2);
        check("t1_post_occ", {30'd0, occupancy}, 32'd0);
        check("t1_post_valid", {31'd0, m_valid}, 32'd0);

        // 2. Single word latency
        m_ready = 1'b1;
        write_word(8'hA5);
        @(negedge clk);
        check("t2_rd_en_t", {31'd0, fifo_rd_en}, 32'd1);
        @(negedge clk);
        check("t2_rd_en_t1", {31'd0, fifo_rd_en}, 32'd0);
        check("t2_valid_t1", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        check("t2_valid_t2", {31'd0, m_valid}, 32'd1);
        check("t2_data_t2", {24'd0, m_data}, 32'hA5);
        check("t2_last_t2", {31'd0, m_last}, 32'd0);
        @(negedge clk);
        check("t2_busy_t3", {31'd0, busy}, 32'd0);
        tick();

        // 3. Streaming at full rate, framing on 0x03 and 0x07
        do_reset(1);
        m_ready = 1'b1;
        fork
            for (int i = 0; i < 8; i++) write_word(8'(i));
            begin
                k = 0;
                @(negedge clk);
                while (!m_valid && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                check("t3_first_beat", {31'd0, m_valid}, 32'd1);
                for (int i = 1; i < 8; i++) begin
                    @(negedge clk);
                    check("t3_gapless", {31'd0, m_valid}, 32'd1);
                end
            end
        join
        tick();
        wait_drain("t3_drain", 50);

        // 4. Backpressure then release
        do_reset(1);
        base = rd_cnt;
        for (int i = 0; i < 8; i++) write_word(8'(i));
        repeat (6) tick();
        check("t4_reads", rd_cnt - base, 32'd3);
        check("t4_occ", {30'd0, occupancy}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_head_data", {24'd0, m_data}, 32'h00);
        end
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        check("t4_refill_first_pop", {31'd0, fifo_rd_en}, 32'd0);
        @(negedge clk);
        check("t4_refill_next", {31'd0, fifo_rd_en}, 32'd1);
        tick();
        wait_drain("t4_drain", 50);

        // 5. Random backpressure with concurrent writes
        do_reset(1);
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    write_word(8'(8'h10 + i));
                    repeat ($urandom_range(0, 2)) tick();
                end
                wait_drain("t5_drain", 500);
                done = 1'b1;
            end
            begin
                k = 0;
                while (!done && k < 2000) begin
                    m_ready = 1'($urandom_range(0, 1));
                    tick();
                    k++;
                end
                m_ready = 1'b1;
            end
        join
        tick();

        // 6. Reset mid-packet, then check framing restarts
        do_reset(1);
        write_word(8'hA0);
        write_word(8'hA1);
        repeat (5) tick();
        check("t6_occ_a", {30'd0, occupancy}, 32'd2);
        base = pop_cnt;
        m_ready = 1'b1;
        tick();
        tick();
        m_ready = 1'b0;
        check("t6_two_pops", pop_cnt - base, 32'd2);
        write_word(8'hA2);
        write_word(8'hA3);
        repeat (5) tick();
        check("t6_occ_b", {30'd0, occupancy}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("t6_cleared_occ", {30'd0, occupancy}, 32'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) write_word(8'(8'hB0 + i));
        wait_drain("t6_drain", 50);

        repeat (5) tick();
        check("end_scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
